// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Multi-cycle control sequencer for the MIPS datapath. It walks each
// instruction through FETCH / DECODE / EXEC / MEM / WB, drives every datapath
// control line plus the PC and IR load enables, waits on the instruction and
// data memory ready handshakes, and stops in HALT with a fault code when it
// sees an illegal instruction or a memory that stays busy too long.
//
// Ports:
//   CLK, RST              rising-edge clock, asynchronous active-high reset
//   Opcode, Funct         instruction fields from the datapath IR
//   Is0                   ALU zero flag (branch decision)
//   IMemReady, DMemReady  instruction / data memory ready handshakes
//   RegDst .. JumpPC      datapath control lines
//   ALUcontrol            ALU operation (0101 add, 0110 sub, 0000 and, 0001 or, 0111 slt)
//   PCWrite, IRWrite      PC and IR load enables
//   State                 current state encoding (debug)
//   Halted, FaultCode     halt indication and reason (01 illegal, 10 timeout)
//   InstrCount            retired instruction count, wraps

module mips_multicycle_control #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int COUNT_W        = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Is0,
    input  logic               IMemReady,
    input  logic               DMemReady,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrc,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               MemToReg,
    output logic               PCSrc,
    output logic               JumpPC,
    output logic [3:0]         ALUcontrol,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic [2:0]         State,
    output logic               Halted,
    output logic [1:0]         FaultCode,
    output logic [COUNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd7
    } state_t;

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    state_t              state;
    state_t              next_state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [5:0]          op_q;
    logic [5:0]          funct_q;
    logic [1:0]          fault_q;
    logic [COUNT_W-1:0]  instr_cnt;

    logic                decode_legal;
    logic                waiting;
    logic                wait_expired;
    logic                retire;

    function automatic logic [3:0] alu_from_funct(input logic [5:0] f);
        case (f)
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h2A:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // Legality is judged on the live IR fields during DECODE, before they are latched.
    always_comb begin
        decode_legal = 1'b0;
        case (Opcode)
            OP_RTYPE: begin
                case (Funct)
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: decode_legal = 1'b1;
                    default:                           decode_legal = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: decode_legal = 1'b1;
            default:                             decode_legal = 1'b0;
        endcase
    end

    // The expiry fires on the TIMEOUT_CYCLES-th consecutive busy cycle, so a
    // ready arriving in that same cycle still takes the normal path.
    assign waiting      = ((state == ST_FETCH) && !IMemReady) ||
                          ((state == ST_MEM)   && !DMemReady);
    assign wait_expired = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; retire marks the last cycle of an instruction.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            ST_FETCH: begin
                if (IMemReady)         next_state = ST_DECODE;
                else if (wait_expired) next_state = ST_HALT;
            end
            ST_DECODE: begin
                if (!decode_legal) begin
                    next_state = ST_HALT;
                end else if (Opcode == OP_J) begin
                    next_state = ST_FETCH;
                    retire     = 1'b1;
                end else begin
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_RTYPE, OP_ADDI: next_state = ST_WB;
                    OP_LW, OP_SW:      next_state = ST_MEM;
                    OP_BEQ: begin
                        next_state = ST_FETCH;
                        retire     = 1'b1;
                    end
                    default:           next_state = ST_HALT;
                endcase
            end
            ST_MEM: begin
                if (DMemReady) begin
                    if (op_q == OP_LW) begin
                        next_state = ST_WB;
                    end else begin
                        next_state = ST_FETCH;
                        retire     = 1'b1;
                    end
                end else if (wait_expired) begin
                    next_state = ST_HALT;
                end
            end
            ST_WB: begin
                next_state = ST_FETCH;
                retire     = 1'b1;
            end
            ST_HALT:  next_state = ST_HALT;
            default:  next_state = ST_FETCH;
        endcase
    end

    // Bookkeeping registers: busy counter, latched IR fields, fault and retire count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt  <= '0;
            op_q      <= '0;
            funct_q   <= '0;
            fault_q   <= 2'b00;
            instr_cnt <= '0;
        end else begin
            if ((next_state != state) || !waiting) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (state == ST_DECODE) begin
                op_q    <= Opcode;
                funct_q <= Funct;
            end
            if ((next_state == ST_HALT) && (state != ST_HALT)) begin
                fault_q <= wait_expired ? FAULT_TIMEOUT : FAULT_ILLEGAL;
            end
            if (retire) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

    // Moore control outputs; the only input-dependent terms are the ready
    // gated fetch enables, the jump in DECODE and the branch decision on Is0.
    always_comb begin
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        MemToReg   = 1'b0;
        PCSrc      = 1'b0;
        JumpPC     = 1'b0;
        ALUcontrol = ALU_ADD;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        Halted     = 1'b0;
        case (state)
            ST_FETCH: begin
                IRWrite = IMemReady;
                PCWrite = IMemReady;
            end
            ST_DECODE: begin
                if (Opcode == OP_J) begin
                    PCWrite = 1'b1;
                    JumpPC  = 1'b1;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        RegDst     = 1'b1;
                        ALUcontrol = alu_from_funct(funct_q);
                    end
                    OP_ADDI, OP_LW, OP_SW: ALUSrc = 1'b1;
                    OP_BEQ: begin
                        ALUcontrol = ALU_SUB;
                        PCSrc      = 1'b1;
                        PCWrite    = Is0;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                ALUSrc = 1'b1;
                if (op_q == OP_LW) MemRead  = 1'b1;
                else               MemWrite = 1'b1;
            end
            ST_WB: begin
                RegWrite = 1'b1;
                if (op_q == OP_LW) begin
                    MemToReg = 1'b1;
                end else if (op_q == OP_RTYPE) begin
                    RegDst     = 1'b1;
                    ALUcontrol = alu_from_funct(funct_q);
                end
            end
            ST_HALT:  Halted = 1'b1;
            default:  ;
        endcase
    end

    assign State      = state;
    assign FaultCode  = fault_q;
    assign InstrCount = instr_cnt;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
// Builds, per instruction, the expected cycle-by-cycle control picture from
// the instruction's phase list (fetch wait, decode, execute, memory wait,
// write back) and replays it against the sequencer, with random instruction
// mixes, random memory latencies and random values on inputs that should not
// matter in a given phase.

module tb_mips_multicycle_control;

    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [5:0]  Opcode = '0;
    logic [5:0]  Funct = '0;
    logic        Is0 = 1'b0;
    logic        IMemReady = 1'b0;
    logic        DMemReady = 1'b0;
    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, PCSrc, JumpPC;
    logic [3:0]  ALUcontrol;
    logic        PCWrite, IRWrite;
    logic [2:0]  State;
    logic        Halted;
    logic [1:0]  FaultCode;
    logic [15:0] InstrCount;

    always #5 CLK = ~CLK;

    mips_multicycle_control #(.TIMEOUT_CYCLES(TIMEOUT), .COUNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Is0(Is0),
        .IMemReady(IMemReady), .DMemReady(DMemReady),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemToReg(MemToReg), .PCSrc(PCSrc), .JumpPC(JumpPC),
        .ALUcontrol(ALUcontrol), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .State(State), .Halted(Halted), .FaultCode(FaultCode), .InstrCount(InstrCount)
    );

    // Control word layout: flags[10:0], ALU op[3:0], state[2:0].
    localparam logic [10:0] F_REGDST   = 11'b10000000000;
    localparam logic [10:0] F_REGWR    = 11'b01000000000;
    localparam logic [10:0] F_ALUSRC   = 11'b00100000000;
    localparam logic [10:0] F_MEMWR    = 11'b00010000000;
    localparam logic [10:0] F_MEMRD    = 11'b00001000000;
    localparam logic [10:0] F_MEMTOREG = 11'b00000100000;
    localparam logic [10:0] F_PCSRC    = 11'b00000010000;
    localparam logic [10:0] F_JUMP     = 11'b00000001000;
    localparam logic [10:0] F_PCW      = 11'b00000000100;
    localparam logic [10:0] F_IRW      = 11'b00000000010;
    localparam logic [10:0] F_HALT     = 11'b00000000001;
    localparam logic [10:0] F_NONE     = 11'b00000000000;

    localparam logic [3:0] A_ADD = 4'b0101;
    localparam logic [3:0] A_SUB = 4'b0110;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    logic [5:0] legal_fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [3:0] fn_alu    [5] = '{4'b0101, 4'b0110, 4'b0000, 4'b0001, 4'b0111};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        is0;
        logic        imr;
        logic        dmr;
        logic [17:0] ctl;
        int          cnt;
        logic [1:0]  fault;
    } cyc_t;

    cyc_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc_idx = 0;
    int         model_cnt = 0;
    logic [1:0] model_fault = 2'b00;

    logic [17:0] obs_ctl;
    assign obs_ctl = {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, PCSrc, JumpPC,
                      PCWrite, IRWrite, Halted, ALUcontrol, State};

    function automatic logic [17:0] word(input logic [2:0] st, input logic [3:0] alu,
                                         input logic [10:0] flags);
        return {flags, alu, st};
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        logic [3:0] a = A_ADD;
        for (int i = 0; i < 5; i++) if (legal_fns[i] == fn) a = fn_alu[i];
        return a;
    endfunction

    function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
        bit ok = 1'b0;
        for (int i = 0; i < 6; i++) if (legal_ops[i] == op) ok = 1'b1;
        if (op == OP_R) begin
            ok = 1'b0;
            for (int i = 0; i < 5; i++) if (legal_fns[i] == fn) ok = 1'b1;
        end
        return ok;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic push_cyc(input logic [5:0] op, input logic [5:0] fn, input logic is0,
                            input logic imr, input logic dmr, input logic [17:0] ctl);
        cyc_t c;
        c.op = op; c.fn = fn; c.is0 = is0; c.imr = imr; c.dmr = dmr;
        c.ctl = ctl; c.cnt = model_cnt; c.fault = model_fault;
        q.push_back(c);
    endtask

    task automatic retire_model();
        model_cnt = (model_cnt + 1) % 65536;
    endtask

    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++)
            push_cyc(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     word(3'd7, A_ADD, F_HALT));
    endtask

    // Expected cycle list for one instruction given its fetch and memory waits.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic is0,
                              input int fwait, input int mwait, input int halt_len);
        logic [10:0] mem_flag;
        for (int i = 0; i < fwait && i < TIMEOUT; i++)
            push_cyc(op, fn, is0, 1'b0, 1'($urandom), word(3'd0, A_ADD, F_NONE));
        if (fwait >= TIMEOUT) begin
            model_fault = 2'b10;
            push_halt(halt_len);
            return;
        end
        push_cyc(op, fn, is0, 1'b1, 1'($urandom), word(3'd0, A_ADD, F_PCW | F_IRW));
        if (!is_legal(op, fn)) begin
            push_cyc(op, fn, is0, 1'($urandom), 1'($urandom), word(3'd1, A_ADD, F_NONE));
            model_fault = 2'b01;
            push_halt(halt_len);
            return;
        end
        if (op == OP_J) begin
            push_cyc(op, fn, is0, 1'($urandom), 1'($urandom), word(3'd1, A_ADD, F_PCW | F_JUMP));
            retire_model();
            return;
        end
        push_cyc(op, fn, is0, 1'($urandom), 1'($urandom), word(3'd1, A_ADD, F_NONE));
        case (op)
            OP_R: begin
                push_cyc(op, fn, is0, 1'($urandom), 1'($urandom), word(3'd2, alu_of(fn), F_REGDST));
                push_cyc(op, fn, is0, 1'($urandom), 1'($urandom),
                         word(3'd4, alu_of(fn), F_REGDST | F_REGWR));
                retire_model();
            end
            OP_ADDI: begin
                push_cyc(op, fn, is0, 1'($urandom), 1'($urandom), word(3'd2, A_ADD, F_ALUSRC));
                push_cyc(op, fn, is0, 1'($urandom), 1'($urandom), word(3'd4, A_ADD, F_REGWR));
                retire_model();
            end
            OP_BEQ: begin
                push_cyc(op, fn, is0, 1'($urandom), 1'($urandom),
                         word(3'd2, A_SUB, F_PCSRC | (is0 ? F_PCW : F_NONE)));
                retire_model();
            end
            default: begin
                mem_flag = (op == OP_LW) ? F_MEMRD : F_MEMWR;
                push_cyc(op, fn, is0, 1'($urandom), 1'($urandom), word(3'd2, A_ADD, F_ALUSRC));
                for (int i = 0; i < mwait && i < TIMEOUT; i++)
                    push_cyc(op, fn, is0, 1'($urandom), 1'b0, word(3'd3, A_ADD, F_ALUSRC | mem_flag));
                if (mwait >= TIMEOUT) begin
                    model_fault = 2'b10;
                    push_halt(halt_len);
                    return;
                end
                push_cyc(op, fn, is0, 1'($urandom), 1'b1, word(3'd3, A_ADD, F_ALUSRC | mem_flag));
                if (op == OP_LW)
                    push_cyc(op, fn, is0, 1'($urandom), 1'($urandom),
                             word(3'd4, A_ADD, F_REGWR | F_MEMTOREG));
                retire_model();
            end
        endcase
    endtask

    // Replays up to max_n queued cycles; entered between a rising and falling edge.
    task automatic applyStimulus(input int max_n);
        cyc_t c;
        int   n = 0;
        while (q.size() > 0 && n < max_n) begin
            c = q.pop_front();
            Opcode = c.op; Funct = c.fn; Is0 = c.is0;
            IMemReady = c.imr; DMemReady = c.dmr;
            @(negedge CLK);
            checkOutput($sformatf("ctl_c%0d", cyc_idx), 32'(obs_ctl), 32'(c.ctl));
            checkOutput($sformatf("count_c%0d", cyc_idx), 32'(InstrCount), 32'(c.cnt));
            checkOutput($sformatf("fault_c%0d", cyc_idx), 32'(FaultCode), 32'(c.fault));
            @(posedge CLK);
            #1;
            n++;
            cyc_idx++;
        end
    endtask

    // Asynchronous reset pulse, checked before any clock edge can intervene.
    task automatic pulse_reset();
        IMemReady = 1'b0;
        DMemReady = 1'b0;
        RST = 1'b1;
        #1;
        checkOutput("rst_state", 32'(State), 32'd0);
        checkOutput("rst_ctl", 32'(obs_ctl), 32'(word(3'd0, A_ADD, F_NONE)));
        checkOutput("rst_count", 32'(InstrCount), 32'd0);
        checkOutput("rst_fault", 32'(FaultCode), 32'd0);
        RST = 1'b0;
        q.delete();
        model_cnt = 0;
        model_fault = 2'b00;
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        repeat (2) @(posedge CLK);
        #1;
        pulse_reset();

        // Directed sequence: R add, stalled lw, sw, both beq outcomes, j.
        push_instr(OP_R, 6'h20, 1'b0, 0, 0, 0);
        push_instr(OP_LW, 6'h00, 1'b0, 0, 3, 0);
        push_instr(OP_SW, 6'h3F, 1'b1, 0, 0, 0);
        push_instr(OP_BEQ, 6'h11, 1'b1, 0, 0, 0);
        push_instr(OP_BEQ, 6'h11, 1'b0, 0, 0, 0);
        push_instr(OP_J, 6'h05, 1'b0, 0, 0, 0);
        push_instr(OP_ADDI, 6'h2A, 1'b0, 1, 0, 0);
        push_instr(OP_R, 6'h2A, 1'b0, 2, 0, 0);
        applyStimulus(1000);

        // Illegal opcode and illegal funct, each halting with fault 01.
        push_instr(6'b111111, 6'h20, 1'b0, 0, 0, 20);
        applyStimulus(1000);
        pulse_reset();
        push_instr(OP_R, 6'h21, 1'b0, 0, 0, 5);
        applyStimulus(1000);
        pulse_reset();

        // Fetch timeout boundary: 15 busy cycles halts, ready on the 15th does not.
        push_instr(OP_R, 6'h22, 1'b0, TIMEOUT, 0, 10);
        applyStimulus(1000);
        pulse_reset();
        push_instr(OP_R, 6'h24, 1'b0, TIMEOUT - 1, 0, 0);
        push_instr(OP_LW, 6'h00, 1'b0, TIMEOUT - 5, TIMEOUT - 1, 0);
        applyStimulus(1000);
        push_instr(OP_SW, 6'h00, 1'b0, 0, TIMEOUT, 10);
        applyStimulus(1000);
        pulse_reset();

        // Random instruction mix with random memory latencies.
        for (int k = 0; k < 60; k++) begin
            op = legal_ops[$urandom_range(0, 5)];
            fn = (op == OP_R) ? legal_fns[$urandom_range(0, 4)] : 6'($urandom);
            push_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end
        applyStimulus(100000);

        // Reset while a load waits in MEM; nothing of it may be retired.
        push_instr(OP_LW, 6'h00, 1'b0, 0, 6, 0);
        applyStimulus(6);
        checkOutput("pre_rst_state", 32'(State), 32'd3);
        pulse_reset();
        push_instr(OP_R, 6'h25, 1'b0, 0, 0, 0);
        applyStimulus(1000);
        @(negedge CLK);
        checkOutput("post_rst_count", 32'(InstrCount), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
